// File: rtl/prog_counter_pkg.sv
// Shared constants for the programmable up/down counter.
//   DEF_*     : default parameter values for prog_counter
//   DIR_*     : encodings of the up_dn input
//   SAT_*     : encodings of the sat input
//   presc_bits: width of the prescaler state register for a given PRESCALE
package prog_counter_pkg;

  localparam int unsigned     DEF_WIDTH    = 4;
  localparam longint unsigned DEF_MOD      = 16;
  localparam int unsigned     DEF_PRESCALE = 1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DN   = 1'b0;
  localparam logic SAT_ON   = 1'b1;
  localparam logic SAT_WRAP = 1'b0;

  // At least one bit so the register exists even when PRESCALE is 1.
  function automatic int unsigned presc_bits(int unsigned prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/prog_counter_if.sv
// Control/status bundle of prog_counter.
//   master: drives en, up_dn, load, load_val, sat, clr_ovf; observes cnt, tc, wrap, ovf
//   slave : the counter itself
interface prog_counter_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat;
  logic             clr_ovf;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up_dn, load, load_val, sat, clr_ovf,
    input  cnt, tc, wrap, ovf
  );

  modport slave (
    input  en, up_dn, load, load_val, sat, clr_ovf,
    output cnt, tc, wrap, ovf
  );

endinterface

// File: rtl/prog_counter_prescaler.sv
// Enable prescaler: counts en-high cycles 0..PRESCALE-1 and raises tick on the last one.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   en    : advance enable; low holds the count
//   clear : synchronous restart to 0, wins over en
//   tick  : en && count == PRESCALE-1 (combinational)
module prog_counter_prescaler
  import prog_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   PW   = presc_bits(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign tick = en && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (tick) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable modulo up/down counter with prescaler, load, saturate/wrap and sticky overflow.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of prog_counter_if
//         inputs  en, up_dn, load, load_val, sat, clr_ovf
//         outputs cnt (registered), tc (combinational), wrap (1-cycle pulse), ovf (sticky)
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = DEF_WIDTH,
  parameter longint unsigned MOD      = DEF_MOD,
  parameter int unsigned     PRESCALE = DEF_PRESCALE
) (
  input  logic           clk,
  input  logic           rst,
  prog_counter_if.slave  bus
);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "prog_counter: WIDTH must be 2..32");
    end
    if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
      $fatal(1, "prog_counter: MOD must be 2..2^WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
      $fatal(1, "prog_counter: PRESCALE must be 1..256");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  logic             tick;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             set_ovf;

  // A load restarts the prescaler so the next step needs a full PRESCALE en-high cycles.
  prog_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .clear (bus.load),
    .tick  (tick)
  );

  always_comb begin
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    set_ovf = 1'b0;
    if (bus.load) begin
      // load_val > MAX is the same as load_val >= MOD without widening past WIDTH.
      cnt_d = (bus.load_val > MAX) ? MAX : bus.load_val;
    end else if (tick) begin
      if (bus.up_dn == DIR_UP) begin
        if (cnt_q == MAX) begin
          set_ovf = 1'b1;
          if (bus.sat == SAT_WRAP) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          set_ovf = 1'b1;
          if (bus.sat == SAT_WRAP) begin
            cnt_d  = MAX;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
    // Setting beats clearing when both happen in the same cycle.
    ovf_d = set_ovf | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;
  assign bus.tc   = (bus.up_dn == DIR_UP) ? (cnt_q == MAX) : (cnt_q == '0);

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter. Three instances share one stimulus stream:
//   0: MOD=10 PRESCALE=3   1: MOD=16 PRESCALE=1   2: MOD=10 PRESCALE=1
// The driver updates a reference model at each falling edge and queues the values expected
// after the next rising edge; the monitor pops and compares them 1 ns after that edge.
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up_dn = 1'b0, load = 1'b0, sat = 1'b0, clr_ovf = 1'b0;
  logic [3:0] load_val = '0;
  logic       rst_drv = 1'b0;

  always #5 clk = ~clk;

  prog_counter_if #(.WIDTH(4)) ifa ();
  prog_counter_if #(.WIDTH(4)) ifb ();
  prog_counter_if #(.WIDTH(4)) ifc ();

  assign ifa.en = en;  assign ifa.up_dn = up_dn;  assign ifa.load = load;
  assign ifa.load_val = load_val;  assign ifa.sat = sat;  assign ifa.clr_ovf = clr_ovf;
  assign ifb.en = en;  assign ifb.up_dn = up_dn;  assign ifb.load = load;
  assign ifb.load_val = load_val;  assign ifb.sat = sat;  assign ifb.clr_ovf = clr_ovf;
  assign ifc.en = en;  assign ifc.up_dn = up_dn;  assign ifc.load = load;
  assign ifc.load_val = load_val;  assign ifc.sat = sat;  assign ifc.clr_ovf = clr_ovf;

  prog_counter #(.WIDTH(4), .MOD(10), .PRESCALE(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  prog_counter #(.WIDTH(4), .MOD(16), .PRESCALE(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  prog_counter #(.WIDTH(4), .MOD(10), .PRESCALE(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [2:0][3:0] cnt;
    logic [2:0]      wrap;
    logic [2:0]      ovf;
    logic [2:0]      tc;
  } obs_t;

  obs_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: counter value, en-high cycles seen since last step, flags.
  int m_mod[3] = '{10, 16, 10};
  int m_ps[3]  = '{3, 1, 1};
  int m_cnt[3];
  int m_pre[3];
  bit m_wrap[3];
  bit m_ovf[3];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit stepped = 0;
      bit flag = 0;
      m_wrap[i] = 0;
      if (!rst_drv) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
        continue;
      end
      if (load) begin
        m_cnt[i] = (int'(load_val) < m_mod[i]) ? int'(load_val) : m_mod[i] - 1;
        m_pre[i] = 0;
      end else if (en) begin
        m_pre[i]++;
        if (m_pre[i] == m_ps[i]) begin
          m_pre[i] = 0;
          stepped = 1;
        end
      end
      if (stepped) begin
        int nxt = up_dn ? m_cnt[i] + 1 : m_cnt[i] - 1;
        if (nxt < 0 || nxt >= m_mod[i]) begin
          flag = 1;
          if (!sat) begin
            m_cnt[i] = (nxt + m_mod[i]) % m_mod[i];
            m_wrap[i] = 1;
          end
        end else begin
          m_cnt[i] = nxt;
        end
      end
      m_ovf[i] = flag ? 1'b1 : (m_ovf[i] && !clr_ovf);
    end
  endtask

  task automatic push_expect();
    obs_t e;
    for (int i = 0; i < 3; i++) begin
      e.cnt[i]  = 4'(m_cnt[i]);
      e.wrap[i] = m_wrap[i];
      e.ovf[i]  = m_ovf[i];
      e.tc[i]   = up_dn ? (m_cnt[i] == m_mod[i] - 1) : (m_cnt[i] == 0);
    end
    sb.push_back(e);
  endtask

  // One clock of stimulus, applied at the falling edge.
  task automatic cycle(bit e, bit ud, bit ld, int lv, bit st, bit cl);
    @(negedge clk);
    rst = rst_drv;
    en = e; up_dn = ud; load = ld; load_val = 4'(lv); sat = st; clr_ovf = cl;
    model_step();
    push_expect();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a.cnt[0] = ifa.cnt; a.wrap[0] = ifa.wrap; a.ovf[0] = ifa.ovf; a.tc[0] = ifa.tc;
        a.cnt[1] = ifb.cnt; a.wrap[1] = ifb.wrap; a.ovf[1] = ifb.ovf; a.tc[1] = ifb.tc;
        a.cnt[2] = ifc.cnt; a.wrap[2] = ifc.wrap; a.ovf[2] = ifc.ovf; a.tc[2] = ifc.tc;
        for (int i = 0; i < 3; i++) begin
          check($sformatf("sb_cnt[%0d]", i),  32'(a.cnt[i]),  32'(e.cnt[i]));
          check($sformatf("sb_wrap[%0d]", i), 32'(a.wrap[i]), 32'(e.wrap[i]));
          check($sformatf("sb_ovf[%0d]", i),  32'(a.ovf[i]),  32'(e.ovf[i]));
          check($sformatf("sb_tc[%0d]", i),   32'(a.tc[i]),   32'(e.tc[i]));
        end
      end
    end
  end

  // Driver
  initial begin
    model_reset();
    #3;
    check("reset_cnt_c", 32'(ifc.cnt), 0);
    check("reset_ovf_c", 32'(ifc.ovf), 0);
    check("reset_tc_dn_c", 32'(ifc.tc), 1);
    rst_drv = 1'b1;

    // Up, wrap mode, 11 steps from 0 on the PRESCALE=1 MOD=10 instance.
    for (int k = 0; k < 10; k++) cycle(1, 1, 0, 0, 0, 0);
    after_edge();
    check("up_wrap_cnt_c", 32'(ifc.cnt), 0);
    check("up_wrap_pulse_c", 32'(ifc.wrap), 1);
    cycle(1, 1, 0, 0, 0, 0);
    after_edge();
    check("up_after_wrap_cnt_c", 32'(ifc.cnt), 1);
    check("up_after_wrap_pulse_c", 32'(ifc.wrap), 0);
    check("up_wrap_ovf_c", 32'(ifc.ovf), 1);

    // Async reset mid-count at 7.
    cycle(0, 1, 1, 7, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    rst_drv = 1'b0;
    #1;
    check("async_rst_cnt_c", 32'(ifc.cnt), 0);
    check("async_rst_ovf_c", 32'(ifc.ovf), 0);
    check("async_rst_wrap_c", 32'(ifc.wrap), 0);
    check("async_rst_cnt_a", 32'(ifa.cnt), 0);
    model_reset();
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    rst_drv = 1'b1;

    // Down, saturate at 0 for 3 enabled cycles.
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 1, 0);
    after_edge();
    check("dn_sat_cnt_c", 32'(ifc.cnt), 0);
    check("dn_sat_wrap_c", 32'(ifc.wrap), 0);
    check("dn_sat_ovf_c", 32'(ifc.ovf), 1);
    check("dn_sat_tc_c", 32'(ifc.tc), 1);
    cycle(0, 0, 0, 0, 1, 1);
    after_edge();
    check("clr_ovf_c", 32'(ifc.ovf), 0);

    // PRESCALE=3: en pattern 1,1,0,1 gives one step; three more en-high give another.
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    after_edge();
    check("presc_hold_a", 32'(ifa.cnt), 0);
    cycle(1, 1, 0, 0, 0, 0);
    after_edge();
    check("presc_step1_a", 32'(ifa.cnt), 1);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    after_edge();
    check("presc_step2_a", 32'(ifa.cnt), 2);

    // Load above range with a tick in the same cycle: clamp, no wrap.
    cycle(1, 1, 1, 12, 0, 0);
    after_edge();
    check("load_clamp_c", 32'(ifc.cnt), 9);
    check("load_clamp_a", 32'(ifa.cnt), 9);
    check("load_inrange_b", 32'(ifb.cnt), 12);
    check("load_nowrap_c", 32'(ifc.wrap), 0);

    // Full-range 16-state wrap with clr_ovf in the same cycle.
    cycle(0, 1, 1, 15, 0, 0);
    cycle(1, 1, 0, 0, 0, 1);
    after_edge();
    check("full_wrap_cnt_b", 32'(ifb.cnt), 0);
    check("full_wrap_pulse_b", 32'(ifb.wrap), 1);
    check("full_wrap_ovf_b", 32'(ifb.ovf), 1);

    // Randomised traffic, including occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst_drv = ($urandom_range(0, 199) != 0);
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 15) == 0),
            int'($urandom_range(0, 15)), 1'($urandom), ($urandom_range(0, 7) == 0));
    end
    rst_drv = 1'b1;
    cycle(0, 1, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #3;
    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
